rs_age_cdb: RTL
===============

# rs_age_cdb

Parametrised reservation station for the ALU path of the out-of-order core. It sits between the issue stage and the ALU functional unit:
- accepts one renamed instruction per cycle;
- snoops `CDB_PORTS` result broadcast channels (ALU, LSB, …) to wake up pending operands;
- dispatches the oldest ready entry to the FU through a valid/ready output register.

Compared with the previous station, it adds configurable depth and broadcast-channel count, oldest-first selection, same-cycle wakeup capture on issue, FU backpressure, and an occupancy count.

## Interface
Parameters:
- `RS_SIZE`, 16 — number of entries; must be ≥2.
- `ROB_LOG`, 4 — ROB tag width.
- `OP_LOG`, 6 — op encoding width.
- `CDB_PORTS`, 2 — number of broadcast channels.
- `CNT_W`, $clog2(RS_SIZE+1) — width of `count`.

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — reset, asynchronous, active-low.
- `rdy` in 1 — global enable; low freezes all state.
- `flush` in 1 — misprediction flush (synchronous).
- `issue_valid` in 1 — new instruction this cycle.
- `issue_op` in OP_LOG.
- `issue_Vj`, `issue_Vk` in 32 each — operand values.
- `issue_Rj`, `issue_Rk` in 1 each — operand ready flags.
- `issue_Qj`, `issue_Qk` in ROB_LOG each — producer tags.
- `issue_Imm`, `issue_CurPC` in 32 each.
- `issue_DestRob` in ROB_LOG.
- `cdb_valid` in CDB_PORTS — per-channel broadcast valid.
- `cdb_RobId` in CDB_PORTS*ROB_LOG — channel c occupies bits [c*ROB_LOG +: ROB_LOG].
- `cdb_value` in CDB_PORTS*32 — channel c occupies bits [c*32 +: 32].
- `fu_valid` out 1 — dispatch register holds an instruction.
- `fu_ready` in 1 — FU accepts it this cycle.
- `fu_op`, `fu_Vj`, `fu_Vk`, `fu_Imm`, `fu_DestRob`, `fu_CurPC` out — dispatch payload.
- `count` out CNT_W — number of busy entries.
- `next_full` out 1 — combinational; high means issue must not send next cycle.

## Operation
- Per entry: `busy`, op, Vj/Vk, Rj/Rk, Qj/Qk, Imm, DestRob, CurPC.
- Age matrix `older[i][j]` (RS_SIZE×RS_SIZE bits).

Allocation:
- The lowest-index free entry is taken.
- On allocation, row i is set to `busy` of all other entries and column i is cleared.

Issue capture:
- If `issue_Rj`=0 and any valid channel carries `issue_Qj` this cycle, the entry is written with Rj=1 and Vj set to that channel's value.
- Same rule for k.

Wakeup:
- Every busy entry with R=0 and Q equal to a valid channel's tag sets R=1 and V to that value.
- If several channels match the same tag, the lowest channel index wins.

Select:
- Ready means busy & Rj & Rk.
- The chosen entry is the ready entry with no ready entry older than it.
- Selection is performed only when `load` = !fu_valid | fu_ready.
- On load with a ready entry: the payload is copied to the fu_* registers, fu_valid goes to 1, and the entry's busy is cleared.
- On load with no ready entry: fu_valid goes to 0.
- Without load, the fu_* registers hold their values.

Occupancy:
- `count` increments on allocation and decrements on select; both in the same cycle leaves it unchanged.
- next_full = (count + issue_valid − select_this_cycle ≥ RS_SIZE).

Flush:
- All busy flags, the age matrix, fu_valid and count are cleared.
- Flush has priority over issue, wakeup and select in the same cycle.

Stall and illegal issue:
- With `rdy`=0, no state changes and broadcasts are ignored.
- issue_valid while count==RS_SIZE is illegal; the bench flags it with an assertion.

## Timing
- Reset (rst=0, async): all busy=0, age matrix=0, fu_valid=0, all fu_* payload=0, count=0.
- Issue in cycle t with both operands ready or captured: the entry is selectable at t+1 and fu_valid=1 at t+2.
- Broadcast in cycle t wakes an entry; it is selectable at t+1.
- Back-to-back dispatch while fu_ready=1: one instruction per cycle.
- fu_ready=0 while fu_valid=1: the payload stays stable and no entry is consumed.
- A freed entry is reusable for an issue in the next cycle.

## Structure
- Shared package/config: `RS_SIZE`, `ROB_LOG`, `OP_LOG`, `CDB_PORTS` defaults and the op encodings, placed beside the existing config defines.
- Sub-module `rs_age_picker`: takes the ready vector and age matrix and returns a one-hot grant plus an any-ready bit; purely combinational.

## Test plan
- Reset mid-operation: with 5 entries busy and fu_valid=1, pull rst low → count=0 and fu_valid=0 immediately, without waiting for a clock edge.
- Age order:
  - Issue op A (tag 3) and then B (tag 5), both waiting on Qj=7.
  - Broadcast channel 1 with tag 7 and value 0x1234.
  - → fu_DestRob=3 first and 5 next cycle, both with fu_Vj=0x1234.
- Issue capture: issue with Rj=0, Qj=2 while channel 0 broadcasts tag 2 with value 0xDEAD in the same cycle → fu_valid 2 cycles later with fu_Vj=0xDEAD.
- Backpressure: hold fu_ready=0 for 4 cycles with 3 ready entries → payload stable, count stays 3, then 3 dispatches on consecutive cycles once fu_ready=1.
- Full:
  - Fill RS_SIZE=16 entries, none ready → next_full=1 and count=16.
  - Wake one entry → next_full=0 in the select cycle.
- Flush: flush asserted in the same cycle as issue_valid and a matching broadcast → count=0 and fu_valid=0 next cycle, and the issued instruction is dropped.

Source files
------------

// File: rtl/rs_age_cdb_pkg.sv
// Shared configuration defaults and ALU op encodings for the ALU reservation station.
package rs_age_cdb_pkg;

  localparam int RS_SIZE_DEF   = 16;
  localparam int ROB_LOG_DEF   = 4;
  localparam int OP_LOG_DEF    = 6;
  localparam int CDB_PORTS_DEF = 2;
  localparam int DATA_W        = 32;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_XOR   = 6'd4,
    OP_SLL   = 6'd5,
    OP_SRL   = 6'd6,
    OP_SRA   = 6'd7,
    OP_SLT   = 6'd8,
    OP_SLTU  = 6'd9,
    OP_LUI   = 6'd10,
    OP_AUIPC = 6'd11
  } alu_op_e;

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-ready picker: grants the ready entry that has no ready entry older than it.
// older[i*RS_SIZE + j] = 1 means entry j is older than entry i.
module rs_age_picker #(
  parameter int RS_SIZE = 16
) (
  input  logic [RS_SIZE-1:0]         ready,
  input  logic [RS_SIZE*RS_SIZE-1:0] older,
  output logic [RS_SIZE-1:0]         grant,
  output logic                       any_ready
);

  // An entry wins when it is ready and none of the entries it considers older are ready.
  always_comb begin
    grant = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      grant[i] = ready[i] & ~(|(older[i*RS_SIZE +: RS_SIZE] & ready));
    end
  end

  assign any_ready = |ready;

endmodule

// File: rtl/rs_age_cdb.sv
// ALU reservation station: oldest-first dispatch, multi-channel CDB wakeup,
// same-cycle capture on issue and a valid/ready dispatch register toward the FU.
module rs_age_cdb
  import rs_age_cdb_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEF,
  parameter int ROB_LOG   = ROB_LOG_DEF,
  parameter int OP_LOG    = OP_LOG_DEF,
  parameter int CDB_PORTS = CDB_PORTS_DEF,
  parameter int CNT_W     = $clog2(RS_SIZE+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic [OP_LOG-1:0]             issue_op,
  input  logic [DATA_W-1:0]             issue_Vj,
  input  logic [DATA_W-1:0]             issue_Vk,
  input  logic                          issue_Rj,
  input  logic                          issue_Rk,
  input  logic [ROB_LOG-1:0]            issue_Qj,
  input  logic [ROB_LOG-1:0]            issue_Qk,
  input  logic [DATA_W-1:0]             issue_Imm,
  input  logic [DATA_W-1:0]             issue_CurPC,
  input  logic [ROB_LOG-1:0]            issue_DestRob,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_LOG-1:0]  cdb_RobId,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_value,
  output logic                          fu_valid,
  input  logic                          fu_ready,
  output logic [OP_LOG-1:0]             fu_op,
  output logic [DATA_W-1:0]             fu_Vj,
  output logic [DATA_W-1:0]             fu_Vk,
  output logic [DATA_W-1:0]             fu_Imm,
  output logic [ROB_LOG-1:0]            fu_DestRob,
  output logic [DATA_W-1:0]             fu_CurPC,
  output logic [CNT_W-1:0]              count,
  output logic                          next_full
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]         busy_q, rj_q, rk_q;
  logic [OP_LOG-1:0]          op_q   [RS_SIZE];
  logic [DATA_W-1:0]          vj_q   [RS_SIZE];
  logic [DATA_W-1:0]          vk_q   [RS_SIZE];
  logic [DATA_W-1:0]          imm_q  [RS_SIZE];
  logic [DATA_W-1:0]          pc_q   [RS_SIZE];
  logic [ROB_LOG-1:0]         qj_q   [RS_SIZE];
  logic [ROB_LOG-1:0]         qk_q   [RS_SIZE];
  logic [ROB_LOG-1:0]         dest_q [RS_SIZE];
  logic [RS_SIZE*RS_SIZE-1:0] older_q;
  logic [CNT_W-1:0]           count_q;

  logic [DATA_W:0]    wk_j [RS_SIZE];
  logic [DATA_W:0]    wk_k [RS_SIZE];
  logic [DATA_W:0]    cap_j, cap_k;
  logic [RS_SIZE-1:0] ready_vec, grant;
  logic               any_ready, any_free, load, sel, alloc;
  logic [IDX_W-1:0]   alloc_idx, gnt_idx;
  logic [CNT_W:0]     occ_next;

  // Returns {hit, value} for a tag; the lowest channel index wins on multiple matches.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_LOG-1:0] tag,
                                                 input logic [CDB_PORTS-1:0] vld,
                                                 input logic [CDB_PORTS*ROB_LOG-1:0] ids,
                                                 input logic [CDB_PORTS*DATA_W-1:0] vals);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_PORTS-1; c >= 0; c--) begin
      if (vld[c] && ids[c*ROB_LOG +: ROB_LOG] == tag) r = {1'b1, vals[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // Broadcast matches for every stored operand tag and for the incoming instruction.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wk_j[i] = cdb_lookup(qj_q[i], cdb_valid, cdb_RobId, cdb_value);
      wk_k[i] = cdb_lookup(qk_q[i], cdb_valid, cdb_RobId, cdb_value);
    end
    cap_j = cdb_lookup(issue_Qj, cdb_valid, cdb_RobId, cdb_value);
    cap_k = cdb_lookup(issue_Qk, cdb_valid, cdb_RobId, cdb_value);
  end

  // Lowest-index free entry for allocation.
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_idx = IDX_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  assign ready_vec = busy_q & rj_q & rk_q;

  rs_age_picker #(.RS_SIZE(RS_SIZE)) u_picker (
    .ready     (ready_vec),
    .older     (older_q),
    .grant     (grant),
    .any_ready (any_ready)
  );

  // One-hot grant to entry index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign load  = !fu_valid || fu_ready;
  assign sel   = load && any_ready;
  assign alloc = issue_valid && any_free;

  assign occ_next  = {1'b0, count_q} + (CNT_W+1)'(issue_valid) - (CNT_W+1)'(sel);
  assign next_full = occ_next >= (CNT_W+1)'(RS_SIZE);
  assign count     = count_q;

  // Entry array, age matrix and occupancy: wakeup, allocation with capture, release on select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      rj_q    <= '0;
      rk_q    <= '0;
      older_q <= '0;
      count_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy_q  <= '0;
        older_q <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && !rj_q[i] && wk_j[i][DATA_W]) begin
            rj_q[i] <= 1'b1;
            vj_q[i] <= wk_j[i][DATA_W-1:0];
          end
          if (busy_q[i] && !rk_q[i] && wk_k[i][DATA_W]) begin
            rk_q[i] <= 1'b1;
            vk_q[i] <= wk_k[i][DATA_W-1:0];
          end
        end
        if (sel) busy_q[gnt_idx] <= 1'b0;
        if (alloc) begin
          busy_q[alloc_idx] <= 1'b1;
          op_q[alloc_idx]   <= issue_op;
          imm_q[alloc_idx]  <= issue_Imm;
          pc_q[alloc_idx]   <= issue_CurPC;
          dest_q[alloc_idx] <= issue_DestRob;
          qj_q[alloc_idx]   <= issue_Qj;
          qk_q[alloc_idx]   <= issue_Qk;
          rj_q[alloc_idx]   <= issue_Rj || cap_j[DATA_W];
          rk_q[alloc_idx]   <= issue_Rk || cap_k[DATA_W];
          vj_q[alloc_idx]   <= (!issue_Rj && cap_j[DATA_W]) ? cap_j[DATA_W-1:0] : issue_Vj;
          vk_q[alloc_idx]   <= (!issue_Rk && cap_k[DATA_W]) ? cap_k[DATA_W-1:0] : issue_Vk;
          // The new entry is younger than everything currently busy; nobody sees it as older.
          for (int j = 0; j < RS_SIZE; j++) begin
            older_q[int'(alloc_idx)*RS_SIZE + j] <= (j != int'(alloc_idx)) && busy_q[j];
            older_q[j*RS_SIZE + int'(alloc_idx)] <= 1'b0;
          end
        end
        count_q <= count_q + CNT_W'(alloc) - CNT_W'(sel);
      end
    end
  end

  // Dispatch register: loads the oldest ready entry whenever it is empty or being consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fu_valid   <= 1'b0;
      fu_op      <= '0;
      fu_Vj      <= '0;
      fu_Vk      <= '0;
      fu_Imm     <= '0;
      fu_DestRob <= '0;
      fu_CurPC   <= '0;
    end else if (rdy) begin
      if (flush) begin
        fu_valid <= 1'b0;
      end else if (load) begin
        fu_valid <= any_ready;
        if (any_ready) begin
          fu_op      <= op_q[gnt_idx];
          fu_Vj      <= vj_q[gnt_idx];
          fu_Vk      <= vk_q[gnt_idx];
          fu_Imm     <= imm_q[gnt_idx];
          fu_DestRob <= dest_q[gnt_idx];
          fu_CurPC   <= pc_q[gnt_idx];
        end
      end
    end
  end

endmodule
